tblink_rpc_hostproc: RTL and testbench
======================================

# tblink_rpc_hostproc

Host-side endpoint of the tblink RPC byte-stream link: the opposite end of the device command processor. It frames local commands into request messages on `tx_`, matches the returned response by ID, and parses device-originated requests from `rx_`, delivering them as indications and framing their responses back. Sits between the host transactor logic and the 8-bit ready/valid link pair.

## Interface
- `REQ_PARAMS_SZ`, default 1: byte capacity of outgoing request params.
- `RSP_SZ`, default 1: byte capacity of received response data.
- `IND_PARAMS_SZ`, default 1: byte capacity of received indication params.
- `IND_RSP_SZ`, default 1: byte capacity of indication response data.
- `uclock`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `tx_dat`/`tx_valid`  out  8/1; `tx_ready`  in  1: byte stream to device (device's inbound port)
- `rx_dat`/`rx_valid`  in  8/1; `rx_ready`  out  1: byte stream from device
- `req_cmd`  in  8 (non-zero); `req_sz`  in  8 (data bytes); `req_params`  in  REQ_PARAMS_SZ*8; `req_valid`  in  1; `req_ready`  out  1
- `rsp_data`  out  RSP_SZ*8; `rsp_sz`  out  8; `rsp_id`  out  8; `rsp_err`  out  1; `rsp_valid`  out  1; `rsp_ready`  in  1
- `ind_cmd`/`ind_id`/`ind_sz`  out  8 each; `ind_params`  out  IND_PARAMS_SZ*8; `ind_valid`  out  1; `ind_ready`  in  1
- `ind_rsp_data`  in  IND_RSP_SZ*8; `ind_rsp_sz`  in  8; `ind_rsp_valid`  in  1; `ind_rsp_ready`  out  1
- `err_unexp`  out  1: one-cycle pulse, response received with nothing outstanding

## Operation
- TX frame (to device): SZ = n+1, CMD, ID, then n data bytes, most-significant byte first (`params[8*(n-1)+:8]` first, `[7:0]` last).
- RX frame (from device): DST (ignored), SZ, CMD, ID, SZ-1 data bytes. CMD==0 is a response; otherwise an indication.
- RX data shifts in left: each byte enters `[7:0]`, prior bytes move up; excess bytes beyond capacity drop off the top. Capture regs cleared at SZ byte.
- TX FSM: IDLE, SZ, CMD, ID, DAT. IND response has priority over a new request in IDLE. Response frame uses CMD=0 and ID = captured `ind_id`.
- `req_ready` = TX IDLE && no outstanding request && no pending `ind_rsp_valid`. `ind_rsp_ready` = TX IDLE && an indication has been accepted and not yet answered.
- ID counter: 8-bit, reset 0, value sent in ID byte, increments when ID byte accepted; wraps 255→0. One outstanding request max; `rsp_id`/`req` ID compared on response.
- RX FSM: DST, SZ, CMD, ID, DAT, HOLD_RSP, HOLD_IND. `rx_ready` high in DST..DAT, low in HOLD states.
- Response, outstanding set: deliver, `rsp_err` = (ID != expected); outstanding clears on `rsp_valid && rsp_ready`. No outstanding: discard, pulse `err_unexp`, return to DST.
- Indication: deliver on `ind_`; after `ind_ready`, RX returns to DST; a second indication is held (HOLD_IND, `rx_ready`=0) until the first is answered.

## Timing
- Reset values: `tx_valid`/`tx_dat`/`rsp_*`/`ind_*`/`err_unexp`/`rx_ready` outputs 0 except `req_ready`=1 and `rx_ready`=1 (both decoded from idle states); ID counter 0.
- `req_valid && req_ready` at cycle N → SZ byte on `tx_` at N+1; one byte per `tx_ready` cycle thereafter; `tx_dat` stable while `tx_valid && !tx_ready`.
- Last RX byte accepted at M → `rsp_valid`/`ind_valid` at M+1, held with stable data until ready.
- SZ==1 frames have no data; SZ==0 treated as SZ==1.
- Reset mid-frame: both FSMs abandon the frame immediately; no partial-frame completion.

## Structure
- Package `tblink_rpc_pkg`: frame field constants (CMD_RSP=0), TX/RX state encodings.
- One sub-module: `tblink_rpc_frame_rx` (RX parser/shift capture); TX framer and ID/outstanding tracking in the top.

## Test plan
- Request cmd=0x05, sz=2, params=0xA1B2, tx_ready=1 → tx bytes 03,05,00,B2? no: 03,05,00,A1,B2; req_ready low until response.
- Then rx 00,01,00,00 → rsp_valid, rsp_sz=0, rsp_id=0, rsp_err=0; next request uses ID 01.
- Rx response ID 07 while expecting 01 → rsp_err=1; rx response with none outstanding → err_unexp pulse, no rsp_valid.
- Rx indication 00,02,09,04,5C → ind_cmd=09, ind_id=04, ind_params=5C; ind_rsp sz=1 data=3E → tx 02,00,04,3E.
- Simultaneous req_valid and ind_rsp_valid → response frame first, request follows; tx_ready toggled randomly holds tx_dat stable.
- Assert reset after CMD byte sent → tx_valid 0 next edge, ID counter 0, req_ready 1.

Source files
------------

// File: rtl/tblink_rpc_pkg.sv
// Shared frame constants, FSM encodings and small helpers for the tblink RPC host endpoint.
// No logic, no latency, no backpressure.
package tblink_rpc_pkg;

  localparam logic [7:0] CMD_RSP = 8'h00;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SZ,
    TX_CMD,
    TX_ID,
    TX_DAT
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_DST,
    RX_SZ,
    RX_CMD,
    RX_ID,
    RX_DAT,
    RX_HOLD_RSP,
    RX_HOLD_IND
  } rx_state_e;

  // Header of the frame currently being sent; n is the data byte count.
  typedef struct packed {
    logic [7:0] n;
    logic [7:0] cmd;
    logic [7:0] id;
  } tx_hdr_t;

  // SZ counts CMD plus data bytes, so data = SZ-1; SZ==0 behaves like SZ==1.
  function automatic logic [7:0] data_len(input logic [7:0] sz);
    return (sz == 8'd0) ? 8'd0 : sz - 8'd1;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tblink_rpc_hostproc_if.sv
// Host-side bundle: 8-bit link pair, local request/response, indication/indication-response.
// Plain wires; master modport is the endpoint, slave modport is its environment.
interface tblink_rpc_hostproc_if #(
  parameter int REQ_PARAMS_SZ = 1,
  parameter int RSP_SZ        = 1,
  parameter int IND_PARAMS_SZ = 1,
  parameter int IND_RSP_SZ    = 1
);
  logic [7:0]                 tx_dat;
  logic                       tx_valid;
  logic                       tx_ready;
  logic [7:0]                 rx_dat;
  logic                       rx_valid;
  logic                       rx_ready;
  logic [7:0]                 req_cmd;
  logic [7:0]                 req_sz;
  logic [REQ_PARAMS_SZ*8-1:0] req_params;
  logic                       req_valid;
  logic                       req_ready;
  logic [RSP_SZ*8-1:0]        rsp_data;
  logic [7:0]                 rsp_sz;
  logic [7:0]                 rsp_id;
  logic                       rsp_err;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [7:0]                 ind_cmd;
  logic [7:0]                 ind_id;
  logic [7:0]                 ind_sz;
  logic [IND_PARAMS_SZ*8-1:0] ind_params;
  logic                       ind_valid;
  logic                       ind_ready;
  logic [IND_RSP_SZ*8-1:0]    ind_rsp_data;
  logic [7:0]                 ind_rsp_sz;
  logic                       ind_rsp_valid;
  logic                       ind_rsp_ready;
  logic                       err_unexp;

  modport master (
    output tx_dat, tx_valid, input tx_ready,
    input rx_dat, rx_valid, output rx_ready,
    input req_cmd, req_sz, req_params, req_valid, output req_ready,
    output rsp_data, rsp_sz, rsp_id, rsp_err, rsp_valid, input rsp_ready,
    output ind_cmd, ind_id, ind_sz, ind_params, ind_valid, input ind_ready,
    input ind_rsp_data, ind_rsp_sz, ind_rsp_valid, output ind_rsp_ready,
    output err_unexp
  );

  modport slave (
    input tx_dat, tx_valid, output tx_ready,
    output rx_dat, rx_valid, input rx_ready,
    output req_cmd, req_sz, req_params, req_valid, input req_ready,
    input rsp_data, rsp_sz, rsp_id, rsp_err, rsp_valid, output rsp_ready,
    input ind_cmd, ind_id, ind_sz, ind_params, ind_valid, output ind_ready,
    output ind_rsp_data, ind_rsp_sz, ind_rsp_valid, input ind_rsp_ready,
    input err_unexp
  );
endinterface

// File: rtl/tblink_rpc_frame_rx.sv
// Parses inbound DST,SZ,CMD,ID,data frames into response or indication captures.
// Result valid 1 cycle after last byte; rx_ready drops while a frame is held for delivery.
module tblink_rpc_frame_rx #(
  parameter int DW = 8
) (
  input  logic          uclock,
  input  logic          reset,
  input  logic [7:0]    rx_dat,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic          outstanding,
  input  logic [7:0]    exp_id,
  input  logic          ind_busy,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_err,
  output logic          ind_valid,
  input  logic          ind_ready,
  output logic          err_unexp,
  output logic [7:0]    cap_cmd,
  output logic [7:0]    cap_id,
  output logic [7:0]    cap_len,
  output logic [DW-1:0] cap_data
);
  import tblink_rpc_pkg::*;

  rx_state_e     state, state_n;
  logic [7:0]    cnt;
  logic          acc, last, unexp_n;
  logic [DW+7:0] sh;

  assign acc       = rx_valid && rx_ready;
  assign sh        = {cap_data, rx_dat};
  assign rx_ready  = (state != RX_HOLD_RSP) && (state != RX_HOLD_IND);
  assign rsp_valid = (state == RX_HOLD_RSP);
  assign rsp_err   = rsp_valid && (cap_id != exp_id);
  // A second indication waits here until the previous one has been answered.
  assign ind_valid = (state == RX_HOLD_IND) && !ind_busy;

  always_comb begin
    last = acc && (((state == RX_ID) && (cap_len == 8'd0)) ||
                   ((state == RX_DAT) && (cnt == 8'd1)));
  end

  always_comb begin
    state_n = state;
    unexp_n = 1'b0;
    case (state)
      RX_DST: if (acc) state_n = RX_SZ;
      RX_SZ:  if (acc) state_n = RX_CMD;
      RX_CMD: if (acc) state_n = RX_ID;
      RX_ID, RX_DAT: begin
        if (last) begin
          if (cap_cmd != CMD_RSP) begin
            state_n = RX_HOLD_IND;
          end else if (outstanding) begin
            state_n = RX_HOLD_RSP;
          end else begin
            state_n = RX_DST;
            unexp_n = 1'b1;
          end
        end else if (acc && (state == RX_ID)) begin
          state_n = RX_DAT;
        end
      end
      RX_HOLD_RSP: if (rsp_ready) state_n = RX_DST;
      RX_HOLD_IND: if (ind_valid && ind_ready) state_n = RX_DST;
      default: state_n = RX_DST;
    endcase
  end

  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      state     <= RX_DST;
      err_unexp <= 1'b0;
      cnt       <= 8'd0;
      cap_cmd   <= 8'd0;
      cap_id    <= 8'd0;
      cap_len   <= 8'd0;
      cap_data  <= '0;
    end else begin
      state     <= state_n;
      err_unexp <= unexp_n;
      if (acc) begin
        case (state)
          RX_SZ: begin
            cap_len  <= data_len(rx_dat);
            cap_cmd  <= 8'd0;
            cap_id   <= 8'd0;
            cap_data <= '0;
          end
          RX_CMD: cap_cmd <= rx_dat;
          RX_ID: begin
            cap_id <= rx_dat;
            cnt    <= cap_len;
          end
          RX_DAT: begin
            cap_data <= sh[DW-1:0];
            cnt      <= cnt - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/tblink_rpc_hostproc.sv
// Host endpoint of the tblink RPC link: frames requests/indication responses, tracks one outstanding ID.
// SZ byte 1 cycle after accept, one byte per tx_ready; requests blocked while one is outstanding.
module tblink_rpc_hostproc #(
  parameter int REQ_PARAMS_SZ = 1,
  parameter int RSP_SZ        = 1,
  parameter int IND_PARAMS_SZ = 1,
  parameter int IND_RSP_SZ    = 1
) (
  input logic                   uclock,
  input logic                   reset,
  tblink_rpc_hostproc_if.master bus
);
  import tblink_rpc_pkg::*;

  localparam int TBYTES = max_i(REQ_PARAMS_SZ, IND_RSP_SZ);
  localparam int TW     = TBYTES * 8;
  localparam int DW     = max_i(RSP_SZ, IND_PARAMS_SZ) * 8;

  tx_state_e     tx_state, tx_state_n;
  tx_hdr_t       hdr;
  logic [TW-1:0] tbuf;
  logic [7:0]    idx, id_cnt, exp_id, ind_id_lat, byte_sel;
  logic          is_req, outstanding, ind_busy;
  logic          tx_idle, tx_acc, req_acc, irsp_acc;
  logic [7:0]    cap_cmd, cap_id, cap_len;
  logic [DW-1:0] cap_data;

  assign tx_idle           = (tx_state == TX_IDLE);
  assign tx_acc            = bus.tx_valid && bus.tx_ready;
  assign bus.tx_valid      = !tx_idle;
  assign bus.req_ready     = tx_idle && !outstanding && !bus.ind_rsp_valid;
  assign bus.ind_rsp_ready = tx_idle && ind_busy;
  assign req_acc           = bus.req_valid && bus.req_ready;
  assign irsp_acc          = bus.ind_rsp_valid && bus.ind_rsp_ready;

  always_comb begin
    byte_sel = 8'h00;
    for (int i = 0; i < TBYTES; i++) begin
      if (idx == 8'(i)) byte_sel = tbuf[i*8 +: 8];
    end
  end

  always_comb begin
    bus.tx_dat = 8'h00;
    case (tx_state)
      TX_SZ:   bus.tx_dat = hdr.n + 8'd1;
      TX_CMD:  bus.tx_dat = hdr.cmd;
      TX_ID:   bus.tx_dat = hdr.id;
      TX_DAT:  bus.tx_dat = byte_sel;
      default: bus.tx_dat = 8'h00;
    endcase
  end

  always_comb begin
    tx_state_n = tx_state;
    case (tx_state)
      TX_IDLE: if (irsp_acc || req_acc) tx_state_n = TX_SZ;
      TX_SZ:   if (tx_acc) tx_state_n = TX_CMD;
      TX_CMD:  if (tx_acc) tx_state_n = TX_ID;
      TX_ID:   if (tx_acc) tx_state_n = (hdr.n == 8'd0) ? TX_IDLE : TX_DAT;
      TX_DAT:  if (tx_acc && (idx == 8'd0)) tx_state_n = TX_IDLE;
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      hdr         <= '0;
      tbuf        <= '0;
      idx         <= 8'd0;
      is_req      <= 1'b0;
      id_cnt      <= 8'd0;
      exp_id      <= 8'd0;
      outstanding <= 1'b0;
      ind_busy    <= 1'b0;
      ind_id_lat  <= 8'd0;
    end else begin
      tx_state <= tx_state_n;
      if (irsp_acc) begin
        hdr    <= '{n: bus.ind_rsp_sz, cmd: CMD_RSP, id: ind_id_lat};
        tbuf   <= TW'(bus.ind_rsp_data);
        is_req <= 1'b0;
      end else if (req_acc) begin
        hdr    <= '{n: bus.req_sz, cmd: bus.req_cmd, id: id_cnt};
        tbuf   <= TW'(bus.req_params);
        is_req <= 1'b1;
        exp_id <= id_cnt;
      end
      if (tx_acc && (tx_state == TX_ID)) begin
        idx <= hdr.n - 8'd1;
        // Only request frames consume an ID; indication responses echo the device's ID.
        if (is_req) id_cnt <= id_cnt + 8'd1;
      end
      if (tx_acc && (tx_state == TX_DAT)) idx <= idx - 8'd1;
      if (req_acc) outstanding <= 1'b1;
      else if (bus.rsp_valid && bus.rsp_ready) outstanding <= 1'b0;
      if (bus.ind_valid && bus.ind_ready) begin
        ind_busy   <= 1'b1;
        ind_id_lat <= bus.ind_id;
      end else if (irsp_acc) begin
        ind_busy <= 1'b0;
      end
    end
  end

  tblink_rpc_frame_rx #(.DW(DW)) u_frame_rx (
    .uclock      (uclock),
    .reset       (reset),
    .rx_dat      (bus.rx_dat),
    .rx_valid    (bus.rx_valid),
    .rx_ready    (bus.rx_ready),
    .outstanding (outstanding),
    .exp_id      (exp_id),
    .ind_busy    (ind_busy),
    .rsp_valid   (bus.rsp_valid),
    .rsp_ready   (bus.rsp_ready),
    .rsp_err     (bus.rsp_err),
    .ind_valid   (bus.ind_valid),
    .ind_ready   (bus.ind_ready),
    .err_unexp   (bus.err_unexp),
    .cap_cmd     (cap_cmd),
    .cap_id      (cap_id),
    .cap_len     (cap_len),
    .cap_data    (cap_data)
  );

  assign bus.rsp_data   = cap_data[RSP_SZ*8-1:0];
  assign bus.rsp_sz     = cap_len;
  assign bus.rsp_id     = cap_id;
  assign bus.ind_cmd    = cap_cmd;
  assign bus.ind_id     = cap_id;
  assign bus.ind_sz     = cap_len;
  assign bus.ind_params = cap_data[IND_PARAMS_SZ*8-1:0];

endmodule

// File: tb/tb_tblink_rpc_hostproc.sv
// Directed bench for the tblink RPC host endpoint: framing, ID matching, indications, reset.
module tb_tblink_rpc_hostproc;
  logic uclock = 1'b0;
  logic reset  = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  always #5 uclock = ~uclock;

  tblink_rpc_hostproc_if #(
    .REQ_PARAMS_SZ(2), .RSP_SZ(2), .IND_PARAMS_SZ(2), .IND_RSP_SZ(2)
  ) bus ();

  tblink_rpc_hostproc #(
    .REQ_PARAMS_SZ(2), .RSP_SZ(2), .IND_PARAMS_SZ(2), .IND_RSP_SZ(2)
  ) dut (
    .uclock (uclock),
    .reset  (reset),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge uclock);
    #1;
  endtask

  task automatic tx_take(input logic [7:0] exp, input string tag);
    int n = 0;
    bus.tx_ready = 1'b1;
    while (bus.tx_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    chk({tag, "_vld"}, bus.tx_valid, 1);
    chk(tag, bus.tx_dat, exp);
    cyc();
  endtask

  // Stall a random number of cycles with the byte presented; it must not move.
  task automatic tx_take_slow(input logic [7:0] exp, input string tag);
    int n = 0;
    int k;
    bus.tx_ready = 1'b0;
    while (bus.tx_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    k = $urandom_range(1, 3);
    repeat (k) begin
      chk({tag, "_stall"}, bus.tx_dat, exp);
      cyc();
    end
    tx_take(exp, tag);
    bus.tx_ready = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    int n = 0;
    bus.rx_dat   = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("rx_rdy", bus.rx_ready, 1);
    cyc();
    bus.rx_valid = 1'b0;
  endtask

  task automatic req_send(input logic [7:0] cmd, input logic [7:0] sz, input logic [15:0] prm);
    bus.req_cmd    = cmd;
    bus.req_sz     = sz;
    bus.req_params = prm;
    bus.req_valid  = 1'b1;
    #1;
    chk("req_rdy_pre", bus.req_ready, 1);
    cyc();
    bus.req_valid = 1'b0;
    #1;
    chk("req_rdy_post", bus.req_ready, 0);
    chk("sz_next_cyc", bus.tx_valid, 1);
  endtask

  task automatic rsp_take();
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    #1;
    chk("rsp_vld_drop", bus.rsp_valid, 0);
  endtask

  initial begin
    bus.tx_ready      = 1'b0;
    bus.rx_dat        = 8'h00;
    bus.rx_valid      = 1'b0;
    bus.req_cmd       = 8'h00;
    bus.req_sz        = 8'h00;
    bus.req_params    = 16'h0000;
    bus.req_valid     = 1'b0;
    bus.rsp_ready     = 1'b0;
    bus.ind_ready     = 1'b0;
    bus.ind_rsp_data  = 16'h0000;
    bus.ind_rsp_sz    = 8'h00;
    bus.ind_rsp_valid = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_tx_vld", bus.tx_valid, 0);
    chk("rst_tx_dat", bus.tx_dat, 0);
    chk("rst_req_rdy", bus.req_ready, 1);
    chk("rst_rx_rdy", bus.rx_ready, 1);
    chk("rst_rsp_vld", bus.rsp_valid, 0);
    chk("rst_ind_vld", bus.ind_valid, 0);
    chk("rst_unexp", bus.err_unexp, 0);
    chk("rst_irsp_rdy", bus.ind_rsp_ready, 0);
    @(negedge uclock) reset = 1'b0;
    cyc();

    // Request 05 / 2 bytes A1B2, ID 00
    req_send(8'h05, 8'd2, 16'hA1B2);
    tx_take(8'h03, "r1_sz");
    tx_take(8'h05, "r1_cmd");
    tx_take(8'h00, "r1_id");
    tx_take(8'hA1, "r1_d1");
    tx_take(8'hB2, "r1_d0");
    chk("r1_done", bus.tx_valid, 0);
    chk("r1_outst", bus.req_ready, 0);

    // Matching response, no data
    rx_send(8'h00); rx_send(8'h01); rx_send(8'h00); rx_send(8'h00);
    chk("p1_vld", bus.rsp_valid, 1);
    chk("p1_sz", bus.rsp_sz, 0);
    chk("p1_id", bus.rsp_id, 0);
    chk("p1_err", bus.rsp_err, 0);
    chk("p1_rx_hold", bus.rx_ready, 0);
    cyc();
    chk("p1_held", bus.rsp_valid, 1);
    rsp_take();
    chk("p1_req_rdy", bus.req_ready, 1);

    // Request with no data uses ID 01; response carries wrong ID 07 and two data bytes
    req_send(8'h11, 8'd0, 16'h0000);
    tx_take(8'h01, "r2_sz");
    tx_take(8'h11, "r2_cmd");
    tx_take(8'h01, "r2_id");
    chk("r2_done", bus.tx_valid, 0);
    rx_send(8'h00); rx_send(8'h03); rx_send(8'h00); rx_send(8'h07);
    rx_send(8'hDE); rx_send(8'hAD);
    chk("p2_vld", bus.rsp_valid, 1);
    chk("p2_err", bus.rsp_err, 1);
    chk("p2_id", bus.rsp_id, 8'h07);
    chk("p2_sz", bus.rsp_sz, 2);
    chk("p2_data", bus.rsp_data, 16'hDEAD);
    rsp_take();

    // Response with nothing outstanding
    rx_send(8'h00); rx_send(8'h01); rx_send(8'h00); rx_send(8'h05);
    chk("ux_pulse", bus.err_unexp, 1);
    chk("ux_no_rsp", bus.rsp_valid, 0);
    cyc();
    chk("ux_one_cyc", bus.err_unexp, 0);
    chk("ux_rx_rdy", bus.rx_ready, 1);

    // Indication cmd 09 id 04 param 5C
    rx_send(8'h00); rx_send(8'h02); rx_send(8'h09); rx_send(8'h04); rx_send(8'h5C);
    chk("i1_vld", bus.ind_valid, 1);
    chk("i1_cmd", bus.ind_cmd, 8'h09);
    chk("i1_id", bus.ind_id, 8'h04);
    chk("i1_sz", bus.ind_sz, 1);
    chk("i1_prm", bus.ind_params, 16'h005C);
    chk("i1_irsp_rdy0", bus.ind_rsp_ready, 0);
    bus.ind_ready = 1'b1;
    cyc();
    bus.ind_ready = 1'b0;
    #1;
    chk("i1_vld_drop", bus.ind_valid, 0);
    chk("i1_irsp_rdy1", bus.ind_rsp_ready, 1);

    // Simultaneous indication response and request: response frame wins
    bus.ind_rsp_sz    = 8'd1;
    bus.ind_rsp_data  = 16'h003E;
    bus.ind_rsp_valid = 1'b1;
    bus.req_cmd       = 8'h22;
    bus.req_sz        = 8'd1;
    bus.req_params    = 16'h00C3;
    bus.req_valid     = 1'b1;
    #1;
    chk("sim_req_blk", bus.req_ready, 0);
    cyc();
    bus.ind_rsp_valid = 1'b0;
    tx_take(8'h02, "ir_sz");
    tx_take(8'h00, "ir_cmd");
    tx_take(8'h04, "ir_id");
    tx_take(8'h3E, "ir_d0");
    chk("sim_req_rdy", bus.req_ready, 1);
    cyc();
    bus.req_valid = 1'b0;
    tx_take_slow(8'h02, "r3_sz");
    tx_take_slow(8'h22, "r3_cmd");
    tx_take_slow(8'h02, "r3_id");
    tx_take_slow(8'hC3, "r3_d0");
    chk("r3_done", bus.tx_valid, 0);
    rx_send(8'h00); rx_send(8'h01); rx_send(8'h00); rx_send(8'h02);
    chk("p3_vld", bus.rsp_valid, 1);
    chk("p3_err", bus.rsp_err, 0);
    rsp_take();

    // Reset after CMD byte of a request frame
    req_send(8'h33, 8'd1, 16'h0044);
    tx_take(8'h02, "r4_sz");
    tx_take(8'h33, "r4_cmd");
    chk("r4_mid", bus.tx_valid, 1);
    reset = 1'b1;
    #1;
    chk("r4_rst_vld", bus.tx_valid, 0);
    chk("r4_rst_req_rdy", bus.req_ready, 1);
    @(negedge uclock) reset = 1'b0;
    cyc();
    chk("r4_stay_idle", bus.tx_valid, 0);
    req_send(8'h01, 8'd0, 16'h0000);
    tx_take(8'h01, "r5_sz");
    tx_take(8'h01, "r5_cmd");
    tx_take(8'h00, "r5_id_rst");
    chk("r5_done", bus.tx_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
